// File: rtl/sram_arbiter_if.sv
// Requester and SRAM pad signal bundle for sram_arbiter.
// The slave modport is the arbiter; master is the surrounding requester/pad environment.
interface sram_arbiter_if;
    logic        a_req;
    logic        a_we;
    logic [19:0] a_addr;
    logic [15:0] a_wdata;
    logic [1:0]  a_be;
    logic        a_ack;
    logic [15:0] a_rdata;

    logic        b_req;
    logic        b_we;
    logic [19:0] b_addr;
    logic [15:0] b_wdata;
    logic [1:0]  b_be;
    logic        b_ack;
    logic [15:0] b_rdata;

    logic [19:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic        sram_lb_n;
    logic        sram_ub_n;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata, a_be,
        output a_ack, a_rdata,
        input  b_req, b_we, b_addr, b_wdata, b_be,
        output b_ack, b_rdata,
        output sram_addr, sram_dq_out, sram_dq_oe,
        output sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n,
        input  sram_dq_in
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata, a_be,
        input  a_ack, a_rdata,
        output b_req, b_we, b_addr, b_wdata, b_be,
        input  b_ack, b_rdata,
        input  sram_addr, sram_dq_out, sram_dq_oe,
        input  sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n,
        output sram_dq_in
    );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port arbiter for a 16-bit asynchronous SRAM: fixed-length access window,
// write turnaround cycle, and a bounded wait for the low-priority port B.
//
// state  | meaning
// IDLE   | pins parked, choose a requester and launch an access
// ACCESS | strobes held for ACCESS_CYCLES clocks, down-counter to terminal count
// TURN   | one clock of data/address hold after a write before releasing the pad
module sram_arbiter #(
    parameter int ACCESS_CYCLES = 2,
    parameter int STARVE_LIMIT  = 8
) (
    input logic          clk_clk,
    input logic          reset_reset_n,
    sram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, TURN} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        sel_b_q, sel_b_d;
    logic        wr_q, wr_d;
    logic [7:0]  starve_q, starve_d;
    logic [19:0] addr_q, addr_d;
    logic [15:0] dq_out_q, dq_out_d;
    logic        dq_oe_q, dq_oe_d;
    logic        ce_n_q, ce_n_d;
    logic        oe_n_q, oe_n_d;
    logic        we_n_q, we_n_d;
    logic        lb_n_q, lb_n_d;
    logic        ub_n_q, ub_n_d;
    logic        a_ack_q, a_ack_d;
    logic        b_ack_q, b_ack_d;
    logic [15:0] a_rdata_q, a_rdata_d;
    logic [15:0] b_rdata_q, b_rdata_d;

    logic        a_elig, b_elig, go_a, go_b;
    logic        gnt_we;
    logic [19:0] gnt_addr;
    logic [15:0] gnt_wdata;
    logic [1:0]  gnt_be;

    // Assertion is immediate; release is retimed to clk_sys through two flops.
    logic [1:0]  rst_sync;
    logic        rst_n;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) rst_sync <= 2'b00;
        else                rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_n = rst_sync[1];

    always_ff @(posedge clk_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sel_b_q   <= 1'b0;
            wr_q      <= 1'b0;
            starve_q  <= '0;
            addr_q    <= '0;
            dq_out_q  <= '0;
            dq_oe_q   <= 1'b0;
            ce_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            lb_n_q    <= 1'b1;
            ub_n_q    <= 1'b1;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_b_q   <= sel_b_d;
            wr_q      <= wr_d;
            starve_q  <= starve_d;
            addr_q    <= addr_d;
            dq_out_q  <= dq_out_d;
            dq_oe_q   <= dq_oe_d;
            ce_n_q    <= ce_n_d;
            oe_n_q    <= oe_n_d;
            we_n_q    <= we_n_d;
            lb_n_q    <= lb_n_d;
            ub_n_q    <= ub_n_d;
            a_ack_q   <= a_ack_d;
            b_ack_q   <= b_ack_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sel_b_d   = sel_b_q;
        wr_d      = wr_q;
        starve_d  = starve_q;
        addr_d    = addr_q;
        dq_out_d  = dq_out_q;
        dq_oe_d   = dq_oe_q;
        ce_n_d    = ce_n_q;
        oe_n_d    = oe_n_q;
        we_n_d    = we_n_q;
        lb_n_d    = lb_n_q;
        ub_n_d    = ub_n_q;
        a_ack_d   = 1'b0;
        b_ack_d   = 1'b0;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;

        // A port whose ack is still high has just finished; it must not be re-captured.
        a_elig    = bus.a_req & ~a_ack_q;
        b_elig    = bus.b_req & ~b_ack_q;
        go_a      = a_elig & (~b_elig | (starve_q < 8'(STARVE_LIMIT)));
        go_b      = b_elig & ~go_a;
        gnt_we    = go_b ? bus.b_we    : bus.a_we;
        gnt_addr  = go_b ? bus.b_addr  : bus.a_addr;
        gnt_wdata = go_b ? bus.b_wdata : bus.a_wdata;
        gnt_be    = go_b ? bus.b_be    : bus.a_be;

        case (state_q)
            IDLE: begin
                if (!bus.b_req) starve_d = '0;
                if (go_a || go_b) begin
                    state_d = ACCESS;
                    cnt_d   = 4'(ACCESS_CYCLES - 1);
                    sel_b_d = go_b;
                    wr_d    = gnt_we;
                    addr_d  = gnt_addr;
                    ce_n_d  = 1'b0;
                    lb_n_d  = ~gnt_be[0];
                    ub_n_d  = ~gnt_be[1];
                    if (gnt_we) begin
                        we_n_d   = 1'b0;
                        dq_oe_d  = 1'b1;
                        dq_out_d = gnt_wdata;
                    end else begin
                        oe_n_d   = 1'b0;
                    end
                    if (go_b)
                        starve_d = '0;
                    else if (bus.b_req && starve_q != 8'hFF)
                        starve_d = starve_q + 8'd1;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    ce_n_d = 1'b1;
                    oe_n_d = 1'b1;
                    we_n_d = 1'b1;
                    lb_n_d = 1'b1;
                    ub_n_d = 1'b1;
                    if (sel_b_q) b_ack_d = 1'b1;
                    else         a_ack_d = 1'b1;
                    if (wr_q) begin
                        state_d = TURN;
                    end else begin
                        state_d = IDLE;
                        if (sel_b_q) b_rdata_d = bus.sram_dq_in;
                        else         a_rdata_d = bus.sram_dq_in;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            TURN: begin
                dq_oe_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.a_ack       = a_ack_q;
    assign bus.b_ack       = b_ack_q;
    assign bus.a_rdata     = a_rdata_q;
    assign bus.b_rdata     = b_rdata_q;
    assign bus.sram_addr   = addr_q;
    assign bus.sram_dq_out = dq_out_q;
    assign bus.sram_dq_oe  = dq_oe_q;
    assign bus.sram_ce_n   = ce_n_q;
    assign bus.sram_oe_n   = oe_n_q;
    assign bus.sram_we_n   = we_n_q;
    assign bus.sram_lb_n   = lb_n_q;
    assign bus.sram_ub_n   = ub_n_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: vector table of single accesses plus
// directed sequences for arbitration, turnaround, reset and handshake corners.
module tb_sram_arbiter;
    logic clk_clk = 1'b0;
    logic reset_reset_n = 1'b0;

    sram_arbiter_if bus ();

    sram_arbiter #(.ACCESS_CYCLES(2), .STARVE_LIMIT(8)) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .bus           (bus.slave)
    );

    always #5 clk_clk = ~clk_clk;

    int tests  = 0;
    int failed = 0;

    // SRAM model and pin monitor
    logic [15:0] mem [int unsigned];
    int  ce_low = 0, oe_low = 0, we_low = 0, dqoe_hi = 0, lb_low = 0, ub_low = 0;
    int  ce_falls = 0, overlap = 0, cyc = 0;
    logic prev_ce = 1'b1;
    byte ack_log [$];
    int  ack_cyc [$];

    function automatic logic [15:0] word(input logic [19:0] addr);
        if (mem.exists(32'(addr))) return mem[32'(addr)];
        if (addr == 20'h00010)     return 16'hBEEF;
        if (addr == 20'hFFFFF)     return 16'hAAAA;
        return 16'h0000;
    endfunction

    always @(negedge clk_clk) begin
        logic [15:0] w;
        cyc++;
        if (bus.sram_dq_oe && !bus.sram_oe_n) overlap++;
        if (!bus.sram_ce_n) ce_low++;
        if (!bus.sram_oe_n) oe_low++;
        if (!bus.sram_we_n) we_low++;
        if (bus.sram_dq_oe) dqoe_hi++;
        if (!bus.sram_lb_n) lb_low++;
        if (!bus.sram_ub_n) ub_low++;
        if (prev_ce && !bus.sram_ce_n) ce_falls++;
        prev_ce = bus.sram_ce_n;
        if (bus.a_ack) begin ack_log.push_back("A"); ack_cyc.push_back(cyc); end
        if (bus.b_ack) begin ack_log.push_back("B"); ack_cyc.push_back(cyc); end
        if (!bus.sram_ce_n && !bus.sram_we_n) begin
            w = word(bus.sram_addr);
            if (!bus.sram_lb_n) w[7:0]  = bus.sram_dq_out[7:0];
            if (!bus.sram_ub_n) w[15:8] = bus.sram_dq_out[15:8];
            mem[32'(bus.sram_addr)] = w;
        end
        bus.sram_dq_in = (!bus.sram_oe_n) ? word(bus.sram_addr) : 16'hDEAD;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          pb;
        bit          we;
        logic [19:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        logic [15:0] exp_data;   // read: rdata; write: memory word afterwards
        int          exp_oe, exp_we, exp_dqoe, exp_lb, exp_ub;
    } vec_t;

    vec_t vecs [8];

    task automatic drive(input vec_t v, input bit req);
        if (v.pb) begin
            bus.b_we = v.we; bus.b_addr = v.addr; bus.b_wdata = v.wdata; bus.b_be = v.be; bus.b_req = req;
        end else begin
            bus.a_we = v.we; bus.a_addr = v.addr; bus.a_wdata = v.wdata; bus.a_be = v.be; bus.a_req = req;
        end
    endtask

    task automatic run_access(input vec_t v, output logic [15:0] rd, output int lat);
        @(negedge clk_clk);
        drive(v, 1'b1);
        lat = 0;
        rd  = '0;
        while (lat < 50) begin
            @(negedge clk_clk);
            lat++;
            if (v.pb ? bus.b_ack : bus.a_ack) begin
                rd = v.pb ? bus.b_rdata : bus.a_rdata;
                break;
            end
        end
        if (v.pb) bus.b_req = 1'b0; else bus.a_req = 1'b0;
        repeat (2) @(negedge clk_clk);
    endtask

    task automatic wait_ack(input bit pb, input string name);
        int n = 0;
        while (n < 20 && !(pb ? bus.b_ack : bus.a_ack)) begin
            @(negedge clk_clk);
            n++;
        end
        check(name, 32'(n < 20), 32'd1);
    endtask

    initial begin
        logic [15:0] rd;
        int lat, s_ce, s_oe, s_we, s_dq, s_lb, s_ub, base, got, acks0, falls0;
        vec_t v;

        vecs[0] = '{0, 0, 20'h00010, 16'h0000, 2'b11, 16'hBEEF, 2, 0, 0, 2, 2};
        vecs[1] = '{1, 1, 20'hFFFFF, 16'h1234, 2'b10, 16'h12AA, 0, 2, 3, 0, 2};
        vecs[2] = '{1, 0, 20'hFFFFF, 16'h0000, 2'b11, 16'h12AA, 2, 0, 0, 2, 2};
        vecs[3] = '{0, 1, 20'h00020, 16'h5678, 2'b11, 16'h5678, 0, 2, 3, 2, 2};
        vecs[4] = '{0, 0, 20'h00020, 16'h0000, 2'b01, 16'h5678, 2, 0, 0, 2, 0};
        vecs[5] = '{1, 0, 20'h00010, 16'h0000, 2'b00, 16'hBEEF, 2, 0, 0, 0, 0};
        vecs[6] = '{0, 1, 20'h00010, 16'h00CD, 2'b01, 16'hBECD, 0, 2, 3, 2, 0};
        vecs[7] = '{1, 1, 20'h00020, 16'hFFFF, 2'b00, 16'h5678, 0, 2, 3, 0, 0};

        bus.a_req = 0; bus.a_we = 0; bus.a_addr = '0; bus.a_wdata = '0; bus.a_be = '0;
        bus.b_req = 0; bus.b_we = 0; bus.b_addr = '0; bus.b_wdata = '0; bus.b_be = '0;

        // Reset state
        repeat (2) @(negedge clk_clk);
        check("rst_strobes", 32'({bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_lb_n, bus.sram_ub_n}), 32'h1F);
        check("rst_dq_oe",   32'(bus.sram_dq_oe), 32'd0);
        check("rst_addr",    32'(bus.sram_addr), 32'd0);
        check("rst_dq_out",  32'(bus.sram_dq_out), 32'd0);
        check("rst_acks",    32'({bus.a_ack, bus.b_ack}), 32'd0);
        check("rst_a_rdata", 32'(bus.a_rdata), 32'd0);
        check("rst_b_rdata", 32'(bus.b_rdata), 32'd0);
        reset_reset_n = 1'b1;
        repeat (4) @(negedge clk_clk);

        // Vector table
        for (int i = 0; i < 8; i++) begin
            s_ce = ce_low; s_oe = oe_low; s_we = we_low; s_dq = dqoe_hi; s_lb = lb_low; s_ub = ub_low;
            run_access(vecs[i], rd, lat);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'd3);
            if (vecs[i].we) check($sformatf("v%0d_memword", i), 32'(word(vecs[i].addr)), 32'(vecs[i].exp_data));
            else            check($sformatf("v%0d_rdata", i),   32'(rd), 32'(vecs[i].exp_data));
            check($sformatf("v%0d_ce_clks", i),   32'(ce_low - s_ce),  32'd2);
            check($sformatf("v%0d_oe_clks", i),   32'(oe_low - s_oe),  32'(vecs[i].exp_oe));
            check($sformatf("v%0d_we_clks", i),   32'(we_low - s_we),  32'(vecs[i].exp_we));
            check($sformatf("v%0d_dqoe_clks", i), 32'(dqoe_hi - s_dq), 32'(vecs[i].exp_dqoe));
            check($sformatf("v%0d_lb_clks", i),   32'(lb_low - s_lb),  32'(vecs[i].exp_lb));
            check($sformatf("v%0d_ub_clks", i),   32'(ub_low - s_ub),  32'(vecs[i].exp_ub));
        end

        // Starvation bound: A writes and B reads both held -> A x8, B, A x8, B
        @(negedge clk_clk);
        bus.a_we = 1; bus.a_addr = 20'h00100; bus.a_wdata = 16'h1111; bus.a_be = 2'b11;
        bus.b_we = 0; bus.b_addr = 20'h00200; bus.b_be = 2'b11;
        base = ack_log.size();
        bus.a_req = 1; bus.b_req = 1;
        for (int n = 0; n < 400 && ack_log.size() < base + 18; n++) @(negedge clk_clk);
        bus.a_req = 0; bus.b_req = 0;
        got = ack_log.size() - base;
        check("starve_ack_count", 32'(got >= 18), 32'd1);
        for (int i = 0; i < 18 && i < got; i++)
            check($sformatf("starve_grant%0d", i), 32'(ack_log[base + i]),
                  (i == 8 || i == 17) ? 32'("B") : 32'("A"));
        repeat (8) @(negedge clk_clk);

        // Write followed by a waiting read: turnaround cycle, no pad overlap
        @(negedge clk_clk);
        bus.b_we = 1; bus.b_addr = 20'h00300; bus.b_wdata = 16'h4321; bus.b_be = 2'b11; bus.b_req = 1;
        @(negedge clk_clk);
        bus.a_we = 0; bus.a_addr = 20'h00300; bus.a_be = 2'b11; bus.a_req = 1;
        wait_ack(1'b1, "turn_b_ack");
        bus.b_req = 0;
        check("turn_cycle_pins", 32'({bus.sram_dq_oe, bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n}), 32'hF);
        @(negedge clk_clk);
        check("turn_release", 32'({bus.sram_dq_oe, bus.sram_oe_n}), 32'b01);
        @(negedge clk_clk);
        check("turn_read_oe", 32'({bus.sram_dq_oe, bus.sram_oe_n}), 32'b00);
        wait_ack(1'b0, "turn_a_ack");
        bus.a_req = 0;
        check("turn_a_rdata", 32'(bus.a_rdata), 32'h4321);
        repeat (3) @(negedge clk_clk);

        // Reset during a write access
        @(negedge clk_clk);
        bus.a_we = 1; bus.a_addr = 20'h00400; bus.a_wdata = 16'h9999; bus.a_be = 2'b11; bus.a_req = 1;
        @(negedge clk_clk);
        check("midrst_in_access", 32'({bus.sram_we_n, bus.sram_ce_n, bus.sram_dq_oe}), 32'b001);
        #2 reset_reset_n = 1'b0;
        #1 check("midrst_pins", 32'({bus.sram_we_n, bus.sram_ce_n, bus.sram_dq_oe}), 32'b110);
        acks0 = ack_log.size();
        bus.a_req = 0;
        repeat (3) @(negedge clk_clk);
        reset_reset_n = 1'b1;
        repeat (5) @(negedge clk_clk);
        check("midrst_no_ack", 32'(ack_log.size() - acks0), 32'd0);
        check("midrst_idle_strobes", 32'({bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n}), 32'b111);
        v = vecs[0];
        run_access(v, rd, lat);
        check("midrst_read_latency", 32'(lat), 32'd3);
        check("midrst_read_rdata", 32'(rd), 32'(word(20'h00010)));

        // Request held across ack: one access per ack, re-grant after ack clears
        @(negedge clk_clk);
        base = ack_log.size(); falls0 = ce_falls;
        bus.a_we = 0; bus.a_addr = 20'h00010; bus.a_be = 2'b11; bus.a_req = 1;
        for (int n = 0; n < 60 && ack_log.size() < base + 3; n++) @(negedge clk_clk);
        bus.a_req = 0;
        repeat (6) @(negedge clk_clk);
        got = ack_log.size() - base;
        check("held_ack_count", 32'(got >= 3), 32'd1);
        check("held_one_access_per_ack", 32'(ce_falls - falls0), 32'(got));
        if (got >= 3) begin
            check("held_interval1", 32'(ack_cyc[base + 1] - ack_cyc[base]), 32'd4);
            check("held_interval2", 32'(ack_cyc[base + 2] - ack_cyc[base + 1]), 32'd4);
        end

        // Dropping req after grant still completes the access
        @(negedge clk_clk);
        bus.b_we = 0; bus.b_addr = 20'h00010; bus.b_be = 2'b11; bus.b_req = 1;
        @(negedge clk_clk);
        bus.b_req = 0;
        wait_ack(1'b1, "drop_req_ack");
        check("drop_req_rdata", 32'(bus.b_rdata), 32'hBECD);
        repeat (3) @(negedge clk_clk);

        check("pad_overlap", 32'(overlap), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single external 16-bit asynchronous SRAM (20-bit word address) between two requesters.
  - Port A: VGA line/frame fetch. High priority, normally read-only.
  - Port B: game-logic/sprite writer or CPU bridge. Read/write.
- Sequences the SRAM pins through a fixed-length access window, inserts bus turnaround after writes, and bounds port B starvation.
- Sits between the requester logic and the top-level SRAM pins. The top level builds the DQ tri-state from sram_dq_out/sram_dq_oe.

Parameters:
- ACCESS_CYCLES, 2, clocks per SRAM access window (legal 2..15).
- STARVE_LIMIT, 8, consecutive A grants while B waits before B is forced next (legal 1..255).

Ports:
- clk_clk  in  1  system clock
- reset_reset_n  in  1  asynchronous active-low reset
- a_req  in  1  port A request, held until a_ack
- a_we  in  1  port A write (1) / read (0)
- a_addr  in  20  port A word address
- a_wdata  in  16  port A write data
- a_be  in  2  port A byte enables, [1]=upper, [0]=lower
- a_ack  out  1  one-cycle completion pulse
- a_rdata  out  16  read data, valid while a_ack=1
- b_req, b_we, b_addr, b_wdata, b_be, b_ack, b_rdata  same as A, for port B
- sram_addr  out  20  SRAM address
- sram_dq_out  out  16  write data to pad
- sram_dq_oe  out  1  pad output enable
- sram_dq_in  in  16  read data from pad
- sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n  out  1 each  SRAM strobes, active low

Behaviour:
- Reset (async assert, sync release):
  - strobes all 1; sram_dq_oe=0; sram_addr=0; sram_dq_out=0.
  - a_ack=b_ack=0; rdata regs=0; starve counter=0; state=IDLE.
- States: IDLE, ACCESS, TURN. All pin and output signals are registered.
- IDLE:
  - Eligible ports are those with req=1 and ack=0 this cycle. The ack=0 rule blocks re-capture of a just-completed request.
  - Selection:
    - A if eligible and (B not eligible or starve<STARVE_LIMIT).
    - Else B.
  - On grant, at the next edge:
    - load sram_addr; ce_n=0; lb_n=~be[0]; ub_n=~be[1].
    - read: oe_n=0.
    - write: we_n=0, dq_oe=1, dq_out=wdata.
    - counter=ACCESS_CYCLES-1; go to ACCESS.
- ACCESS:
  - Counter decrements each cycle; pins are held for exactly ACCESS_CYCLES cycles.
  - At the edge where counter==0:
    - ce_n, oe_n, we_n, lb_n, ub_n go to 1.
    - selected ack=1 for one cycle.
    - read: rdata <= sram_dq_in (sampled at that edge), then go to IDLE.
    - write: go to TURN, with dq_oe, dq_out and sram_addr held.
- TURN (write only):
  - One cycle of data/address hold. At the next edge dq_oe=0, then go to IDLE.
  - No grant is issued in TURN.
- Latency:
  - Read ack is ACCESS_CYCLES+1 clocks after the IDLE cycle in which req is seen.
  - Back-to-back read throughput is one access per ACCESS_CYCLES+1 clocks; writes take one extra clock.
- Starve counter:
  - Increments (saturating at 255) on each A grant while b_req=1.
  - Clears on a B grant, or when b_req=0 in IDLE.
- Requester rules:
  - addr/we/wdata/be must be stable from req until ack. The arbiter latches them at grant, so post-grant changes have no effect.
  - Dropping req before ack does not abort the access; ack still pulses.
- Byte enables:
  - be=2'b00 still performs a full-timing cycle with lb_n=ub_n=1 and returns ack.
  - rdata always captures all 16 bits.
- Simultaneous a_req and b_req in IDLE: resolved by the selection rule above; only one grant per IDLE cycle.
- Reset mid-access: all strobes deassert immediately (asynchronously), dq_oe=0, and no ack is issued.
- sram_dq_oe is never 1 while sram_oe_n=0.

Test Plan:
- Reset, then A read addr 0x00010 with memory model word 0xBEEF → ce_n/oe_n low for exactly 2 clocks; a_ack pulses 3 clocks after req; a_rdata=0xBEEF.
- B write addr 0xFFFFF data 0x1234 be=2'b10 → we_n low 2 clocks, ub_n=0, lb_n=1, dq_oe high 3 clocks; b_ack once; model upper byte=0x12, lower byte unchanged.
- a_req and b_req both held high continuously → grant order A×8, B, A×8, B...; starve counter clears after each B grant.
- Write then immediate read (B write, A waiting) → one TURN cycle where dq_oe=1 and all strobes high; dq_oe=0 before oe_n falls; no overlap.
- reset_reset_n asserted mid-ACCESS during a write → same-cycle we_n=ce_n=1, dq_oe=0, no ack; after release, IDLE and a new A read completes normally.
- req held high across its ack → exactly one access per ack; the same port is re-granted only from the following IDLE cycle, once ack=0.
